// File: rtl/seq_divider.sv
// seq_divider: multi-cycle unsigned restoring divider, one quotient bit per clock.
// Define SEQ_DIVIDER_SIGNED_EN to add the signed_mode input (two's complement).
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef SEQ_DIVIDER_SIGNED_EN
  input  logic             signed_mode,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   prem_q, prem_d;
  logic [WIDTH-1:0] shq_q, shq_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH+1:0] trial;
  logic [WIDTH+1:0] diff;
  logic             step_ge;
  logic [WIDTH:0]   step_rem;
  logic [WIDTH-1:0] step_q;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  // Extra top bit makes the trial-subtract sign visible as diff MSB.
  assign trial    = {prem_q, shq_q[WIDTH-1]};
  assign diff     = trial - {2'b00, dvs_q};
  assign step_ge  = ~diff[WIDTH+1];
  assign step_rem = step_ge ? diff[WIDTH:0] : trial[WIDTH:0];
  assign step_q   = {shq_q[WIDTH-2:0], step_ge};

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic neg_q_q, neg_q_d;
  logic neg_r_q, neg_r_d;
  logic a_neg;
  logic b_neg;

  assign a_neg = signed_mode & dividend[WIDTH-1];
  assign b_neg = signed_mode & divisor[WIDTH-1];
  assign a_mag = a_neg ? -dividend : dividend;
  assign b_mag = b_neg ? -divisor : divisor;
  assign q_fix = neg_q_q ? -step_q : step_q;
  assign r_fix = neg_r_q ? -step_rem[WIDTH-1:0]
                         : step_rem[WIDTH-1:0];
`else
  assign a_mag = dividend;
  assign b_mag = divisor;
  assign q_fix = step_q;
  assign r_fix = step_rem[WIDTH-1:0];
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prem_d  = prem_q;
    shq_d   = shq_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
`ifdef SEQ_DIVIDER_SIGNED_EN
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          shq_d  = a_mag;
          dvs_d  = b_mag;
          prem_d = '0;
          cnt_d  = CNT_W'(WIDTH);
`ifdef SEQ_DIVIDER_SIGNED_EN
          neg_q_d = a_neg ^ b_neg;
          neg_r_d = a_neg;
`endif
          if (divisor == '0) begin
            state_d = DONE;
            quo_d   = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        prem_d = step_rem;
        shq_d  = step_q;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
          quo_d   = q_fix;
          rem_d   = r_fix;
          dbz_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prem_q  <= '0;
      shq_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prem_q  <= prem_d;
      shq_q   <= shq_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
`ifdef SEQ_DIVIDER_SIGNED_EN
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
`endif
    end
  end

  assign busy        = (state_q == CALC);
  assign done        = (state_q == DONE);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: randomized and directed checks of seq_divider
// against an arithmetic reference model (WIDTH=8 and WIDTH=4).
module tb_seq_divider;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start, start4;
  logic [7:0] a, b, q, r;
  logic       busy, done, dbz;
  logic [3:0] a4, b4, q4, r4;
  logic       busy4, done4, dbz4;
`ifdef SEQ_DIVIDER_SIGNED_EN
  logic       sm, sm4;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  seq_divider #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start),
    .dividend(a), .divisor(b),
`ifdef SEQ_DIVIDER_SIGNED_EN
    .signed_mode(sm),
`endif
    .busy(busy), .done(done),
    .quotient(q), .remainder(r),
    .div_by_zero(dbz)
  );

  seq_divider #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4),
    .dividend(a4), .divisor(b4),
`ifdef SEQ_DIVIDER_SIGNED_EN
    .signed_mode(sm4),
`endif
    .busy(busy4), .done(done4),
    .quotient(q4), .remainder(r4),
    .div_by_zero(dbz4)
  );

  // Launch one op; lat = clock edges after the start edge until
  // done is seen (-1 on timeout), bn = cycles busy was seen high.
  task automatic run_op(input logic [7:0] ai, input logic [7:0] bi,
                        output int lat, output int bn);
    @(negedge clk);
    a = ai; b = bi; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = -1; bn = 0;
    for (int k = 0; k <= 40; k++) begin
      if (done === 1'b1) begin lat = k; break; end
      if (busy === 1'b1) bn++;
      @(negedge clk);
    end
  endtask

  task automatic run_op4(input logic [3:0] ai, input logic [3:0] bi,
                         output int lat);
    @(negedge clk);
    a4 = ai; b4 = bi; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    lat = -1;
    for (int k = 0; k <= 40; k++) begin
      if (done4 === 1'b1) begin lat = k; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total_cnt++;
    if ({busy, done, q, r, dbz} !== 19'd0)
      $display("FAIL reset8 got %h want 0", {busy, done, q, r, dbz});
    else pass_cnt++;
    total_cnt++;
    if ({busy4, done4, q4, r4, dbz4} !== 11'd0)
      $display("FAIL reset4 got %h want 0", {busy4, done4, q4, r4, dbz4});
    else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({busy, done, q, r, dbz} !== 19'd0)
      $display("FAIL idle_after_reset got %h want 0", {busy, done, q, r, dbz});
    else pass_cnt++;
  endtask

  task automatic test_basic();
    int lat, bn;
    run_op(8'd200, 8'd7, lat, bn);
    total_cnt++;
    if (q !== 8'd28) $display("FAIL basic_q got %0d want 28", q);
    else pass_cnt++;
    total_cnt++;
    if (r !== 8'd4) $display("FAIL basic_r got %0d want 4", r);
    else pass_cnt++;
    total_cnt++;
    if (dbz !== 1'b0) $display("FAIL basic_dbz got %b want 0", dbz);
    else pass_cnt++;
    total_cnt++;
    if (lat != 8) $display("FAIL basic_latency got %0d want 8", lat);
    else pass_cnt++;
    total_cnt++;
    if (bn != 8) $display("FAIL basic_busy_cycles got %0d want 8", bn);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (done !== 1'b0) $display("FAIL basic_done_pulse got %b want 0", done);
    else pass_cnt++;
  endtask

  task automatic test_div_zero();
    int lat, bn;
    run_op(8'd13, 8'd0, lat, bn);
    total_cnt++;
    if ({q, r, dbz} !== {8'd255, 8'd13, 1'b1})
      $display("FAIL dz_result got q=%0d r=%0d f=%b want q=255 r=13 f=1", q, r, dbz);
    else pass_cnt++;
    total_cnt++;
    if (lat != 0 || bn != 0)
      $display("FAIL dz_timing got lat=%0d busy=%0d want lat=0 busy=0", lat, bn);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    a = 8'd5; b = 8'd9; start = 1'b1;
    @(negedge clk);
    a = 8'd255; b = 8'd1;
    lat = -1;
    for (int k = 0; k <= 40; k++) begin
      if (done === 1'b1) begin lat = k; break; end
      @(negedge clk);
    end
    total_cnt++;
    if ({q, r, lat[7:0]} !== {8'd0, 8'd5, 8'd8})
      $display("FAIL b2b_first got q=%0d r=%0d lat=%0d want 0 5 8", q, r, lat);
    else pass_cnt++;
    @(negedge clk);
    start = 1'b0;
    total_cnt++;
    if ({busy, done, q} !== {1'b1, 1'b0, 8'd0})
      $display("FAIL b2b_accept got busy=%b done=%b q=%0d want 1 0 0", busy, done, q);
    else pass_cnt++;
    lat = -1;
    for (int k = 0; k <= 40; k++) begin
      if (done === 1'b1) begin lat = k; break; end
      start = (k == 3);
      if (k == 3) begin a = 8'd1; b = 8'd1; end
      @(negedge clk);
    end
    start = 1'b0;
    total_cnt++;
    if ({q, r, dbz, lat[7:0]} !== {8'd255, 8'd0, 1'b0, 8'd8})
      $display("FAIL b2b_second got q=%0d r=%0d f=%b lat=%0d want 255 0 0 8",
               q, r, dbz, lat);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({busy, done} !== 2'b00)
      $display("FAIL calc_start_ignored got busy=%b done=%b want 0 0", busy, done);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int lat, bn;
    bit seen;
    @(negedge clk);
    a = 8'd100; b = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total_cnt++;
    if ({busy, done, q, r, dbz} !== 19'd0)
      $display("FAIL async_reset got %h want 0", {busy, done, q, r, dbz});
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    total_cnt++;
    if (seen) $display("FAIL abort_no_done got done=1 want 0");
    else pass_cnt++;
    run_op(8'd100, 8'd3, lat, bn);
    total_cnt++;
    if ({q, r, lat[7:0]} !== {8'd33, 8'd1, 8'd8})
      $display("FAIL after_abort got q=%0d r=%0d lat=%0d want 33 1 8", q, r, lat);
    else pass_cnt++;
  endtask

  task automatic test_random();
    int lat, bn, eq, er, el;
    logic [7:0] ra, rb;
    logic ef;
    for (int i = 0; i < 30; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      if (rb == 0) begin eq = 255; er = ra; ef = 1'b1; el = 0; end
      else begin eq = ra / rb; er = ra % rb; ef = 1'b0; el = 8; end
      run_op(ra, rb, lat, bn);
      total_cnt++;
      if ({q, r, dbz} !== {eq[7:0], er[7:0], ef})
        $display("FAIL rand %0d/%0d got q=%0d r=%0d f=%b want q=%0d r=%0d f=%b",
                 ra, rb, q, r, dbz, eq, er, ef);
      else pass_cnt++;
      total_cnt++;
      if (lat != el)
        $display("FAIL rand_lat %0d/%0d got %0d want %0d", ra, rb, lat, el);
      else pass_cnt++;
    end
  endtask

  task automatic test_exhaustive4();
    int lat, eq, er, el, bad, inv_bad;
    logic ef;
    bad = 0; inv_bad = 0;
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        if (ib == 0) begin eq = 15; er = ia; ef = 1'b1; el = 0; end
        else begin eq = ia / ib; er = ia % ib; ef = 1'b0; el = 4; end
        run_op4(4'(ia), 4'(ib), lat);
        if ({q4, r4, dbz4} !== {eq[3:0], er[3:0], ef} || lat != el) begin
          bad++;
          if (bad <= 4)
            $display("FAIL w4 %0d/%0d got q=%0d r=%0d f=%b lat=%0d want %0d %0d %b %0d",
                     ia, ib, q4, r4, dbz4, lat, eq, er, ef, el);
        end
        if (ib != 0 &&
            (int'(q4) * ib + int'(r4) != ia || int'(r4) >= ib))
          inv_bad++;
      end
    end
    total_cnt++;
    if (bad != 0) $display("FAIL w4_exhaustive got %0d bad want 0", bad);
    else pass_cnt++;
    total_cnt++;
    if (inv_bad != 0) $display("FAIL w4_invariant got %0d bad want 0", inv_bad);
    else pass_cnt++;
  endtask

`ifdef SEQ_DIVIDER_SIGNED_EN
  task automatic test_signed();
    int lat, bn, sa, sb, eq, er, el;
    logic [7:0] ta [4] = '{8'hF9, 8'h07, 8'h80, 8'hFB};
    logic [7:0] tb [4] = '{8'h02, 8'hFE, 8'hFF, 8'h00};
    logic [7:0] va, vb;
    logic ef;
    sm = 1'b1;
    for (int i = 0; i < 24; i++) begin
      if (i < 4) begin va = ta[i]; vb = tb[i]; end
      else begin
        va = 8'($urandom_range(0, 255));
        vb = 8'($urandom_range(0, 255));
      end
      sa = int'($signed(va));
      sb = int'($signed(vb));
      if (sb == 0) begin eq = -1; er = sa; ef = 1'b1; el = 0; end
      else begin eq = sa / sb; er = sa % sb; ef = 1'b0; el = 8; end
      run_op(va, vb, lat, bn);
      total_cnt++;
      if ({q, r, dbz} !== {eq[7:0], er[7:0], ef} || lat != el)
        $display("FAIL signed %0d/%0d got q=%h r=%h f=%b lat=%0d want %h %h %b %0d",
                 sa, sb, q, r, dbz, lat, eq[7:0], er[7:0], ef, el);
      else pass_cnt++;
    end
    sm = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1;
    start = 1'b0; start4 = 1'b0;
    a = '0; b = '0; a4 = '0; b4 = '0;
`ifdef SEQ_DIVIDER_SIGNED_EN
    sm = 1'b0; sm4 = 1'b0;
`endif
    test_reset();
    test_basic();
    test_div_zero();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_exhaustive4();
`ifdef SEQ_DIVIDER_SIGNED_EN
    test_signed();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
